fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Write-side arbiter for the async FIFO. Shares the single FIFO write port among `NUM_REQ` requesters in the `clk_w` domain using round-robin priority with bounded bursts. Tracks free FIFO slots with a credit counter, because the FIFO does not export `full`. Sits between the producer blocks and the FIFO's `data_in`/`write_en` pins; the read side returns credits through a pulse already synchronised into `clk_w`.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `WIDTH`, 8: data word width; equals the FIFO `WIDTH`.
- `DEPTH`, 32: FIFO depth (power of two); initial and maximum credit count.
- `BURST`, 4: maximum consecutive grants to one requester while another is waiting (≥1).
- `clk_w` in 1: write-domain clock. One clock; every flop is on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req` in `NUM_REQ`: per-requester request; hold high with valid data until granted.
- `req_data` in `NUM_REQ*WIDTH`: requester i's word is at `[i*WIDTH +: WIDTH]`.
- `credit_ret` in 1: one-cycle pulse meaning one FIFO slot was freed by the reader.
- `grant` out `NUM_REQ`: registered, one-hot or zero. A high bit means that requester's word was taken at the previous edge.
- `fifo_data_in` out `WIDTH`: to FIFO `data_in`.
- `fifo_write_en` out 1: to FIFO `write_en`; equals `|grant`.
- `credits` out `addr_width(DEPTH)+1`: free slots as known to the arbiter.
- `stall` out 1: high when requests are pending and `credits==0`.
- `ovf_err` out 1: sticky; set when `credit_ret` arrives while `credits==DEPTH`.

## Operation
- State machine, updated each edge:
  - IDLE: no owner.
  - BURST: owner `own` active; `bcnt` counts that owner's grants.
  - STALL: requests pending, no credits.
- Winner selection: a rotating priority search that starts at `ptr+1` mod `NUM_REQ`, where `ptr` is the last owner.
- IDLE:
  - if `|req` and `credits!=0`: grant the winner, set `own`=winner, `ptr`=winner, `bcnt`=1, go to BURST;
  - if `|req` and `credits==0`: go to STALL;
  - otherwise stay in IDLE.
- BURST, evaluated in this order:
  1. If `credits==0` and `|req`: go to STALL.
  2. If `req[own]` and `bcnt<BURST`: grant `own` again and increment `bcnt`.
  3. Otherwise, if any other request is pending: grant the RR winner (`bcnt`=1, `ptr` updated).
  4. Otherwise, if `req[own]` alone: grant `own` and set `bcnt`=1.
  5. Otherwise go to IDLE.
- STALL:
  - on `credits!=0`, re-arbitrate as from IDLE with `ptr` unchanged;
  - if `req` falls to 0, go to IDLE.
- Every grant, in the same edge: `grant[i]`←1, `fifo_data_in`←`req_data[i]`, `fifo_write_en`←1.
- Credits:
  - write and `credit_ret` in the same edge: `credits` unchanged;
  - write alone: decrement;
  - `credit_ret` alone: increment, saturating at `DEPTH` (the excess pulse sets `ovf_err`).
- `credits` never underflows, because a grant requires `credits!=0` before the edge.
- Width: all counter arithmetic is in `addr_width(DEPTH)+1` bits, with no wrap.

## Timing
- Values after reset assertion (asynchronous): `grant`=0, `fifo_write_en`=0, `fifo_data_in`=0, `credits`=`DEPTH`, `stall`=0, `ovf_err`=0, state IDLE, `ptr`=`NUM_REQ-1` (requester 0 wins first), `bcnt`=0.
- Latency:
  - `req` sampled at edge N produces `grant`/`fifo_write_en` high during cycle N+1;
  - the FIFO writes `fifo_data_in` at edge N+1.
- Handshake:
  - `grant[i]` high during a cycle means `req_data[i]` was consumed at the prior edge;
  - before the next edge the requester must either present its next word or drop `req[i]`, otherwise the word is written again.
- Throughput: one word per cycle sustained while credits last; no bubble on owner change.
- `stall` is registered and reflects the state after the edge.
- Reset mid-burst: the in-flight write is abandoned, `credits` is restored to `DEPTH`, and the FIFO must be reset at the same time by the shared `rst`.

## Structure
- Package `fifo_arb_pkg`: the `addr_width` function, the state enum {IDLE, BURST, STALL}, and the credit-width localparam.
- Sub-module `rr_pick`: combinational rotating-priority one-hot picker (inputs `req`, `ptr`; output winner index and `valid`), parameterised by `NUM_REQ`.
- The top level holds the FSM, credit counter, burst counter and output registers.

## Test plan
- Reset, then `req`=4'b0001 held for 3 cycles → `grant`=0001 for 3 cycles, `credits` 32→29, `fifo_data_in` follows requester 0's data each cycle.
- `req`=4'b1111 held, `BURST`=4 → grant order: 0 four times, 1 four times, 2 four times, 3 four times, then 0 again, with no idle cycle.
- 32 grants with no `credit_ret` → `credits`=0, `stall`=1, `fifo_write_en`=0; one `credit_ret` pulse → exactly one further grant, then `stall` again.
- `credit_ret` pulsed on the same edge as a grant at `credits`=5 → `credits` stays 5.
- `credit_ret` pulsed at `credits`=32 → `credits` stays 32, `ovf_err`=1 and remains set until reset.
- `rst` asserted in the middle of a burst with `credits`=10 → immediately `grant`=0, `credits`=32; after release, requester 0 has priority.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and sizing helpers for the async-FIFO write-side arbiter.
//   arb_state_t   : arbiter FSM states (idle / burst in progress / out of credit)
//   addr_width()  : address bits needed to index a FIFO of the given depth
//   credit_width(): bits needed to hold a credit count of 0..depth inclusive
//   CREDIT_W      : credit width for the default 32-deep FIFO
// ---------------------------------------------------------------------------
package fifo_arb_pkg;

    // ST_ prefix keeps the state names clear of the BURST parameter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so that a completely empty FIFO (credits == depth) fits.
    function automatic int credit_width(input int depth);
        return addr_width(depth) + 1;
    endfunction

    localparam int CREDIT_W = credit_width(32);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundle between the producers, the arbiter and the FIFO write pins.
//   req, req_data   : per-requester request and packed data words
//   credit_ret      : one-cycle pulse, one FIFO slot freed by the reader
//   grant           : one-hot (or zero) grant, registered
//   fifo_data_in    : word to the FIFO data_in pins
//   fifo_write_en   : FIFO write strobe, equals |grant
//   credits         : free FIFO slots as known to the arbiter
//   stall, ovf_err  : out-of-credit indicator and sticky credit-overflow flag
// Modport master is the arbiter side; slave is the producer/FIFO side.
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32
);
    localparam int CW = fifo_arb_pkg::credit_width(DEPTH);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     credit_ret;
    logic [NUM_REQ-1:0]       grant;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     fifo_write_en;
    logic [CW-1:0]            credits;
    logic                     stall;
    logic                     ovf_err;

    modport master (
        input  req, req_data, credit_ret,
        output grant, fifo_data_in, fifo_write_en, credits, stall, ovf_err
    );

    modport slave (
        output req, req_data, credit_ret,
        input  grant, fifo_data_in, fifo_write_en, credits, stall, ovf_err
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker. The search starts one position
// after ptr and wraps, so ptr itself has the lowest priority.
//   req   in  NUM_REQ : request vector
//   ptr   in  PW      : last owner
//   idx   out PW      : winning requester index (0 when valid is low)
//   valid out 1       : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [PW-1:0]      idx,
    output logic               valid
);

    // cand[gi] is the requester at distance gi+1 from ptr; hit[gi] its request.
    logic [PW-1:0]      cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        logic [PW:0] sum;
        assign sum      = {1'b0, ptr} + (PW+1)'(gi + 1);
        assign cand[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ))
                                                    : sum[PW-1:0];
        assign hit[gi]  = req[cand[gi]];
    end

    // Scan from farthest to nearest so the nearest hit is the last assignment.
    always_comb begin
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single async-FIFO write port among NUM_REQ producers in the
// clk_w domain: round-robin ownership with bursts of at most BURST grants
// while others wait, and a credit counter standing in for the FIFO's
// missing full flag.
//   clk_w in  1 : write-domain clock (rising edge)
//   rst   in  1 : asynchronous active-low reset, shared with the FIFO
//   bus   master modport of fifo_wr_arbiter_if:
//         req/req_data/credit_ret in; grant/fifo_data_in/fifo_write_en/
//         credits/stall/ovf_err out, all registered.
// A grant bit high during a cycle means that requester's word was taken at
// the edge that started the cycle.
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 32,
    parameter int BURST   = 4
) (
    input  logic              clk_w,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int CW = credit_width(DEPTH);
    localparam int PW = $clog2(NUM_REQ);
    localparam int BW = $clog2(BURST + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    arb_state_t         state_reg, state_next;
    logic [PW-1:0]      own_reg, own_next;
    logic [PW-1:0]      ptr_reg, ptr_next;
    logic [BW-1:0]      bcnt_reg, bcnt_next;
    logic [CW-1:0]      credits_reg, credits_next;
    logic [NUM_REQ-1:0] grant_reg;
    logic [WIDTH-1:0]   data_reg;
    logic               stall_reg;
    logic               ovf_reg;

    logic               wr_next;
    logic [PW-1:0]      widx;
    logic [PW-1:0]      pick_idx;
    logic               pick_valid;
    logic               have_cred;
    logic [NUM_REQ-1:0] others;

    logic [WIDTH-1:0]   word [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
        assign word[gi] = bus.req_data[gi*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr_reg),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign have_cred = (credits_reg != '0);
    assign others    = bus.req & ~(NUM_REQ'(1) << own_reg);

    // Next-state and grant decision.
    always_comb begin
        state_next = state_reg;
        own_next   = own_reg;
        ptr_next   = ptr_reg;
        bcnt_next  = bcnt_reg;
        wr_next    = 1'b0;
        widx       = own_reg;

        unique case (state_reg)
            ST_BURST: begin
                if (!have_cred && pick_valid) begin
                    state_next = ST_STALL;
                end else if (bus.req[own_reg] && (bcnt_reg < BW'(BURST))) begin
                    wr_next   = 1'b1;
                    bcnt_next = bcnt_reg + BW'(1);
                end else if (|others) begin
                    // ptr == own here, so the search reaches every other
                    // requester before coming back to the owner.
                    wr_next   = 1'b1;
                    widx      = pick_idx;
                    own_next  = pick_idx;
                    ptr_next  = pick_idx;
                    bcnt_next = BW'(1);
                end else if (bus.req[own_reg]) begin
                    wr_next   = 1'b1;
                    bcnt_next = BW'(1);
                end else begin
                    state_next = ST_IDLE;
                    bcnt_next  = '0;
                end
            end
            default: begin
                // ST_IDLE and ST_STALL arbitrate identically from ptr.
                if (!pick_valid) begin
                    state_next = ST_IDLE;
                end else if (!have_cred) begin
                    state_next = ST_STALL;
                end else begin
                    state_next = ST_BURST;
                    wr_next    = 1'b1;
                    widx       = pick_idx;
                    own_next   = pick_idx;
                    ptr_next   = pick_idx;
                    bcnt_next  = BW'(1);
                end
            end
        endcase
    end

    // Credit bookkeeping: a write and a return on the same edge cancel.
    always_comb begin
        credits_next = credits_reg;
        if (wr_next && !bus.credit_ret) begin
            credits_next = credits_reg - CW'(1);
        end else if (!wr_next && bus.credit_ret && (credits_reg != FULL)) begin
            credits_next = credits_reg + CW'(1);
        end
    end

    always_ff @(posedge clk_w or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            own_reg     <= '0;
            ptr_reg     <= PW'(NUM_REQ - 1);
            bcnt_reg    <= '0;
            credits_reg <= FULL;
            grant_reg   <= '0;
            data_reg    <= '0;
            stall_reg   <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            own_reg     <= own_next;
            ptr_reg     <= ptr_next;
            bcnt_reg    <= bcnt_next;
            credits_reg <= credits_next;
            grant_reg   <= wr_next ? (NUM_REQ'(1) << widx) : '0;
            if (wr_next) begin
                data_reg <= word[widx];
            end
            stall_reg   <= (state_next == ST_STALL);
            // A return while the counter is already full means a lost or
            // duplicated pulse upstream; remember it until reset.
            if (bus.credit_ret && (credits_reg == FULL)) begin
                ovf_reg <= 1'b1;
            end
        end
    end

    assign bus.grant         = grant_reg;
    assign bus.fifo_write_en = |grant_reg;
    assign bus.fifo_data_in  = data_reg;
    assign bus.credits       = credits_reg;
    assign bus.stall         = stall_reg;
    assign bus.ovf_err       = ovf_reg;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Directed phases followed by a randomized phase, all compared cycle by
// cycle against a reference model built from the arbitration rules:
// an owner keeps the port while it requests and has taken fewer than BURST
// words; otherwise the port goes to the first requester after the last one
// served; nothing moves without credit.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 32;
    localparam int B  = 4;

    logic clk_w = 1'b0;
    logic rst   = 1'b1;

    always #5 clk_w = ~clk_w;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W),
        .DEPTH   (D),
        .BURST   (B)
    ) dut (
        .clk_w (clk_w),
        .rst   (rst),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int           m_owner;   // -1 when nobody holds the port
    int           m_run;     // words taken by m_owner in its current run
    int           m_last;    // last requester served
    int           m_cred;
    bit           m_ovf;
    logic [N-1:0] e_grant;
    logic [W-1:0] e_data;
    bit           e_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, ".grant"},   32'(bus.grant),         32'(e_grant));
        check({phase, ".wr_en"},   32'(bus.fifo_write_en), 32'(|e_grant));
        check({phase, ".data"},    32'(bus.fifo_data_in),  32'(e_data));
        check({phase, ".credits"}, 32'(bus.credits),       32'(m_cred));
        check({phase, ".stall"},   32'(bus.stall),         32'(e_stall));
        check({phase, ".ovf"},     32'(bus.ovf_err),       32'(m_ovf));
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_run   = 0;
        m_last  = N - 1;
        m_cred  = D;
        m_ovf   = 1'b0;
        e_grant = '0;
        e_data  = '0;
        e_stall = 1'b0;
    endtask

    function automatic int first_after(input logic [N-1:0] r, input int last);
        for (int d = 1; d <= N; d++) begin
            if (r[(last + d) % N]) return (last + d) % N;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs with fresh random data, advance the model,
    // clock the DUT and compare.
    task automatic step(input string phase, input logic [N-1:0] r, input bit cr);
        logic [N*W-1:0] d;
        int             who;
        for (int i = 0; i < N; i++) begin
            d[i*W +: W] = W'($urandom);
        end
        bus.req        = r;
        bus.req_data   = d;
        bus.credit_ret = cr;

        who     = -1;
        e_stall = (r != '0) && (m_cred == 0);
        if (r == '0 || m_cred == 0) begin
            m_owner = -1;
        end else begin
            if (m_owner >= 0 && r[m_owner] && m_run < B) begin
                who = m_owner;
                m_run++;
            end else begin
                who   = first_after(r, m_last);
                m_run = 1;
            end
            m_owner = who;
            m_last  = who;
        end
        if (cr && m_cred == D) m_ovf = 1'b1;
        if (who >= 0 && !cr) m_cred--;
        else if (who < 0 && cr && m_cred < D) m_cred++;
        e_grant = (who >= 0) ? (N'(1) << who) : '0;
        if (who >= 0) e_data = d[who*W +: W];

        @(posedge clk_w);
        #1;
        check_all(phase);
    endtask

    // Assert reset wherever the bench currently is (possibly mid-burst),
    // check the asynchronous effect at once, release on a falling edge.
    task automatic apply_reset();
        bus.req        = '0;
        bus.credit_ret = 1'b0;
        rst            = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        repeat (2) @(posedge clk_w);
        @(negedge clk_w);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req        = '0;
        bus.req_data   = '0;
        bus.credit_ret = 1'b0;
        #1;

        // Single requester, three cycles.
        apply_reset();
        repeat (3) step("single", 4'b0001, 1'b0);
        check("single.credits_29", 32'(bus.credits), 32'd29);

        // All requesting: bursts of four in rotation, no gaps.
        apply_reset();
        for (int k = 0; k < 17; k++) begin
            step("rr", 4'b1111, 1'b0);
            check("rr.order", 32'(bus.grant), 32'(N'(1) << ((k / 4) % N)));
        end

        // Exhaust credits, then release exactly one.
        apply_reset();
        repeat (34) step("drain", 4'b1111, 1'b0);
        check("drain.credits_0", 32'(bus.credits), 32'd0);
        check("drain.stall",     32'(bus.stall), 32'd1);
        check("drain.wr_en",     32'(bus.fifo_write_en), 32'd0);
        step("drain", 4'b1111, 1'b1);
        check("drain.credits_1", 32'(bus.credits), 32'd1);
        step("drain", 4'b1111, 1'b0);
        check("drain.one_more",  32'(bus.fifo_write_en), 32'd1);
        step("drain", 4'b1111, 1'b0);
        check("drain.restall",   32'(bus.stall), 32'd1);
        check("drain.no_write",  32'(bus.fifo_write_en), 32'd0);

        // Write and credit return on the same edge cancel.
        apply_reset();
        repeat (27) step("cancel", 4'b0001, 1'b0);
        check("cancel.credits_5", 32'(bus.credits), 32'd5);
        step("cancel", 4'b0001, 1'b1);
        check("cancel.still_5",   32'(bus.credits), 32'd5);
        check("cancel.wrote",     32'(bus.fifo_write_en), 32'd1);

        // Return while full: saturate and latch the error.
        apply_reset();
        step("ovf", 4'b0000, 1'b1);
        check("ovf.credits_32", 32'(bus.credits), 32'd32);
        check("ovf.set",        32'(bus.ovf_err), 32'd1);
        repeat (3) step("ovf", 4'b0000, 1'b0);
        step("ovf", 4'b0001, 1'b0);
        check("ovf.sticky",     32'(bus.ovf_err), 32'd1);

        // Reset in the middle of a burst.
        apply_reset();
        repeat (22) step("midrst", 4'b1111, 1'b0);
        check("midrst.credits_10", 32'(bus.credits), 32'd10);
        apply_reset();
        step("midrst", 4'b1111, 1'b0);
        check("midrst.req0_first", 32'(bus.grant), 32'd1);

        // Randomized traffic.
        apply_reset();
        for (int k = 0; k < 400; k++) begin
            logic [N-1:0] r;
            r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r = '0;
            step("rand", r, ($urandom_range(0, 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
